// File: rtl/ww_pipe_pkg.sv
// Shared types and widths for the WideWord pipeline stage registers.
package ww_pipe_pkg;

  localparam int WW_DATA_W      = 128;
  localparam int WW_INSTR_W     = 32;
  localparam int WW_CTRL_W      = 64;
  localparam int WW_CTRL_USED_W = 54;

  typedef struct packed {
    logic [WW_CTRL_W-WW_CTRL_USED_W-1:0] pad;
    logic [4:0]  aluop;
    logic [1:0]  ww;
    logic        mem_en;
    logic        mem_wr_en;
    logic [20:0] mem_addr;
    logic [15:0] wbyteen;
    logic        regwren;
    logic [4:0]  rwraddr;
    logic        reginmuxop;
    logic        aluinmuxop;
  } ww_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/ww_skid_slot.sv
// One-entry payload+valid holding register with load and clear; clear wins over load.
module ww_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] pay_q, pay_d;
  logic         valid_q, valid_d;

  always_comb begin
    pay_d   = pay_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      pay_d   = d;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pay_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pay_q   <= pay_d;
      valid_q <= valid_d;
    end
  end

  assign q     = pay_q;
  assign valid = valid_q;

endmodule

// File: rtl/ww_pipe_stage.sv
// Flow-controlled pipeline stage register with flush and saturating stall counter.
// Optional skid slot (registered in_ready) enabled by PIPE_STAGE_SKID_EN.
//
// state    | meaning
// EMPTY    | no valid entry held
// FULL     | main register holds a valid entry
// SKID     | main and skid slot both hold entries (skid build only)
module ww_pipe_stage
  import ww_pipe_pkg::*;
#(
  parameter int CTRL_W  = WW_CTRL_W,
  parameter int DATA_W  = WW_DATA_W,
  parameter int INSTR_W = WW_INSTR_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int PAY_W = CTRL_W + DATA_W + INSTR_W;

  pipe_state_e      state_q, state_d;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] in_pay;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             in_xfer, out_xfer;

  assign in_pay    = {in_ctrl, in_data, in_instr};
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign {out_ctrl, out_data, out_instr} = main_q;
  assign stall_cnt = stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
  logic [PAY_W-1:0] skid_pay;
  logic             skid_valid, skid_load, skid_clear;

  ww_skid_slot #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_pay),
    .q     (skid_pay),
    .valid (skid_valid)
  );

  assign in_ready = !skid_valid;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_load  = 1'b0;
    skid_clear = flush;
`endif
    // Flush drops everything, including an input accepted this cycle.
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = in_pay;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (in_xfer && out_ready) begin
            main_d = in_pay;
          end else if (in_xfer) begin
            skid_load = 1'b1;
            state_d   = ST_SKID;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
`else
          if (in_xfer) begin
            main_d = in_pay;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_SKID: begin
          if (out_xfer) begin
            main_d     = skid_pay;
            skid_clear = 1'b1;
            state_d    = ST_FULL;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_ww_pipe_stage.sv
// Self-checking bench for ww_pipe_stage: directed table, corner sequences, random vs queue model.
module tb_ww_pipe_stage;

  logic         clk;
  logic         reset, flush, in_valid, out_ready;
  logic [63:0]  in_ctrl;
  logic [127:0] in_data;
  logic [31:0]  in_instr;
  logic         in_ready, out_valid, in_ready4, out_valid4;
  logic [63:0]  out_ctrl, out_ctrl4;
  logic [127:0] out_data, out_data4;
  logic [31:0]  out_instr, out_instr4;
  logic [15:0]  stall_cnt;
  logic [3:0]   stall_cnt4;

  int errors = 0;
  int checks = 0;

  ww_pipe_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_instr(in_instr), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .out_instr(out_instr),
    .stall_cnt(stall_cnt)
  );

  ww_pipe_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_instr(in_instr), .out_valid(out_valid4),
    .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_data(out_data4), .out_instr(out_instr4),
    .stall_cnt(stall_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef PIPE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // Reference model: ordered queue of entries, capacity DEPTH.
  logic [223:0] mq[$];
  logic [223:0] held;
  int           mcnt, mcnt4;
  bit           known = 0;

  typedef struct {
    logic         rst, fl, iv, orr;
    logic [127:0] data;
    logic         chk;
    logic         ev;
    logic [127:0] ed;
    logic         eir;
  } rec_t;

  rec_t tbl [8];

  function automatic rec_t mk(logic rst, logic fl, logic iv, logic orr, logic [127:0] data,
                              logic chk, logic ev, logic [127:0] ed, logic eir);
    rec_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.orr = orr; r.data = data;
    r.chk = chk; r.ev = ev; r.ed = ed; r.eir = eir;
    return r;
  endfunction

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_ready();
    if (DEPTH == 2) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  task automatic begin_cycle(input logic rst, input logic fl, input logic iv, input logic orr,
                             input logic [63:0] c, input logic [127:0] d, input logic [31:0] ins);
    reset = rst; flush = fl; in_valid = iv; out_ready = orr;
    in_ctrl = c; in_data = d; in_instr = ins;
    @(negedge clk);
    if (known) begin
      chk("out_valid", {223'd0, out_valid}, {223'd0, mq.size() > 0});
      chk("in_ready", {223'd0, in_ready}, {223'd0, model_ready()});
      chk("payload", {out_ctrl, out_data, out_instr}, held);
      chk("stall_cnt", {208'd0, stall_cnt}, 224'(mcnt));
      chk("stall_cnt4", {220'd0, stall_cnt4}, 224'(mcnt4));
    end
  endtask

  task automatic end_cycle();
    bit inx, outx;
    if (reset) begin
      mq.delete();
      held  = '0;
      mcnt  = 0;
      mcnt4 = 0;
      known = 1;
    end else begin
      if (mq.size() > 0 && !out_ready) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt4 < 15) mcnt4++;
      end
      inx  = in_valid && model_ready();
      outx = (mq.size() > 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (outx) void'(mq.pop_front());
        if (inx) mq.push_back({in_ctrl, in_data, in_instr});
        if (mq.size() > 0) held = mq[0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic rst, input logic fl, input logic iv, input logic orr,
                     input logic [127:0] d);
    begin_cycle(rst, fl, iv, orr, {2{d[31:0]}}, d, ~d[31:0]);
  endtask

  logic [127:0] a5, bb;

  initial begin
    a5 = {16{8'hA5}};
    bb = 128'hB0;

    // Directed stream: reset with all inputs high, then 1,2,3,4 back to back.
    tbl[0] = mk(1, 1, 1, 1, '1,  0, 0, 0, 1);
    tbl[1] = mk(0, 0, 0, 1, 0,   1, 0, 0, 1);
    tbl[2] = mk(0, 0, 1, 1, 1,   1, 0, 0, 1);
    tbl[3] = mk(0, 0, 1, 1, 2,   1, 1, 1, 1);
    tbl[4] = mk(0, 0, 1, 1, 3,   1, 1, 2, 1);
    tbl[5] = mk(0, 0, 1, 1, 4,   1, 1, 3, 1);
    tbl[6] = mk(0, 0, 0, 1, 0,   1, 1, 4, 1);
    tbl[7] = mk(0, 0, 0, 1, 0,   1, 0, 4, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].orr, tbl[i].data);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_valid", i), {223'd0, out_valid}, {223'd0, tbl[i].ev});
        chk($sformatf("tbl%0d_data", i), {96'd0, out_data}, {96'd0, tbl[i].ed});
        chk($sformatf("tbl%0d_ready", i), {223'd0, in_ready}, {223'd0, tbl[i].eir});
        chk($sformatf("tbl%0d_cnt", i), {208'd0, stall_cnt}, 224'd0);
      end
      end_cycle();
    end

    // Stall for 5 cycles while upstream keeps offering entries.
    cyc(1, 0, 0, 0, 0); end_cycle();
    cyc(0, 0, 1, 0, a5); end_cycle();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, bb + 128'(i));
      chk("stall_hold", {96'd0, out_data}, {96'd0, a5});
`ifdef PIPE_STAGE_SKID_EN
      chk("skid_ready", {223'd0, in_ready}, {223'd0, (i == 0)});
`else
      chk("stall_ready", {223'd0, in_ready}, 224'd0);
`endif
      end_cycle();
    end
    cyc(0, 0, 0, 1, 0);
    chk("stall_data", {96'd0, out_data}, {96'd0, a5});
    chk("stall_cnt5", {208'd0, stall_cnt}, 224'd5);
    end_cycle();
    cyc(0, 0, 0, 1, 0);
`ifdef PIPE_STAGE_SKID_EN
    chk("skid_order_valid", {223'd0, out_valid}, 224'd1);
    chk("skid_order_data", {96'd0, out_data}, {96'd0, bb});
`else
    chk("drain_valid", {223'd0, out_valid}, 224'd0);
`endif
    end_cycle();
    cyc(0, 0, 0, 1, 0); end_cycle();

    // Flush while FULL with an input offered.
    cyc(1, 0, 0, 0, 0); end_cycle();
    cyc(0, 0, 1, 0, 128'h11); end_cycle();
    cyc(0, 1, 1, 0, 128'h22); end_cycle();
    cyc(0, 0, 0, 1, 0);
    chk("flush_valid", {223'd0, out_valid}, 224'd0);
    chk("flush_cnt", {208'd0, stall_cnt}, 224'd1);
    end_cycle();
    cyc(0, 0, 0, 1, 0);
    chk("flush_gone", {223'd0, out_valid}, 224'd0);
    end_cycle();

    // Counter saturation.
    cyc(1, 0, 0, 0, 0); end_cycle();
    cyc(0, 0, 1, 0, 128'h33); end_cycle();
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0); end_cycle();
    end
    cyc(0, 0, 0, 0, 0);
    chk("sat_cnt4", {220'd0, stall_cnt4}, 224'd15);
    chk("cnt20", {208'd0, stall_cnt}, 224'd20);
    end_cycle();

    // Reset while both slots are occupied (SKID in the skid build).
    cyc(1, 0, 0, 0, 0); end_cycle();
    cyc(0, 0, 1, 0, 128'h44); end_cycle();
    cyc(0, 0, 1, 0, 128'h55); end_cycle();
    cyc(1, 0, 1, 0, 128'h66); end_cycle();
    cyc(0, 0, 0, 0, 0);
    chk("rst_valid", {223'd0, out_valid}, 224'd0);
    chk("rst_cnt", {208'd0, stall_cnt}, 224'd0);
    chk("rst_ready", {223'd0, in_ready}, 224'd1);
    chk("rst_data", {96'd0, out_data}, 224'd0);
    end_cycle();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      begin_cycle($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
                  $urandom_range(9) < 6, {$urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, $urandom);
      end_cycle();
    end
    cyc(0, 0, 0, 1, 0); end_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
